// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled 8N1 UART receiver with one-entry output register, framing-error and overrun pulses
module uart_rx_os #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_edge,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_error,
    output logic       overrun
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state, state_n;
    logic [TW-1:0]          tick, tick_n;
    logic [2:0]             bit_cnt, bit_n;
    logic [7:0]             shift, shift_n, data_n;
    logic                   valid_n, fe_n, ov_n, deliver;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus all receiver state; line idles high out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '1;
            state       <= IDLE;
            tick        <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
            state       <= state_n;
            tick        <= tick_n;
            bit_cnt     <= bit_n;
            shift       <= shift_n;
            data        <= data_n;
            data_valid  <= valid_n;
            frame_error <= fe_n;
            overrun     <= ov_n;
        end
    end

    // Frame sequencing on sample edges, then delivery/ack handling of the output register
    always_comb begin
        state_n = state;
        tick_n  = tick;
        bit_n   = bit_cnt;
        shift_n = shift;
        fe_n    = 1'b0;
        deliver = 1'b0;
        if (sample_edge) begin
            case (state)
                IDLE: if (!rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
                START: if (tick == HALF_LAST) begin
                    state_n = rx_s ? IDLE : DATA;
                    tick_n  = '0;
                    bit_n   = '0;
                end else tick_n = tick + TW'(1);
                DATA: if (tick == FULL_LAST) begin
                    shift_n[bit_cnt] = rx_s;
                    tick_n  = '0;
                    state_n = (bit_cnt == 3'd7) ? STOP : DATA;
                    bit_n   = (bit_cnt == 3'd7) ? bit_cnt : bit_cnt + 3'd1;
                end else tick_n = tick + TW'(1);
                STOP: if (tick == FULL_LAST) begin
                    tick_n  = '0;
                    state_n = rx_s ? IDLE : BRK;
                    deliver = rx_s;
                    fe_n    = !rx_s;
                end else tick_n = tick + TW'(1);
                BRK: state_n = rx_s ? IDLE : BRK;
                default: state_n = IDLE;
            endcase
        end
        data_n  = (deliver && (!data_valid || data_ack)) ? shift : data;
        valid_n = deliver ? (data_valid || !data_ack || 1'b1) : (data_valid && !data_ack);
        ov_n    = deliver && data_valid && !data_ack;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
UART receiver, the receive-side counterpart to the UART transmitter: 8N1 frames, LSB first, idle-high line. The serial input is synchronised and sampled at an oversampled tick rate. Start is validated at the start-bit midpoint, and data and stop bits are sampled at their midpoints. Each received byte is held in a one-entry output register with a valid/ack handshake, with framing-error and overrun reporting. It sits between the board RX pin and the test-logic byte consumer.

Parameters:
OVERSAMPLE, 16, sample_edge ticks per bit period; must be even and >= 4.
SYNC_STAGES, 2, flip-flops in the rx synchroniser; must be >= 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-low reset.
sample_edge  input  1  one-clk strobe at OVERSAMPLE x baud rate; the FSM advances only on cycles where it is 1.
rx  input  1  asynchronous serial line, idle 1.
data  output  8  received byte; valid while data_valid=1.
data_valid  output  1  high while an unconsumed byte is held.
data_ack  input  1  consumer accepts the held byte.
frame_error  output  1  one-clk pulse when the sampled stop bit is 0.
overrun  output  1  one-clk pulse when a completed byte is dropped.

Behaviour:
- Reset (rst=0, async): sync chain=1, state=IDLE, counters=0, data=0, data_valid=0, frame_error=0, overrun=0. Takes effect immediately, including mid-frame. A partial frame is discarded.
- Synchroniser: rx passes through SYNC_STAGES FFs every clk, independent of sample_edge. Its output is rx_s.
- tick counter width is clog2(OVERSAMPLE). bit counter is 3 bits. Both update only on sample_edge.
- IDLE: rx_s=0 -> START, tick=0.
- START: tick++. At tick==OVERSAMPLE/2-1:
  - rx_s=0 -> DATA, tick=0, bit=0.
  - rx_s=1 -> IDLE (glitch rejected, nothing reported).
- DATA: tick++. At tick==OVERSAMPLE-1: shift[bit]<=rx_s, tick=0.
  - bit==7 -> STOP.
  - otherwise bit++.
- STOP: tick++. At tick==OVERSAMPLE-1:
  - rx_s=1 -> deliver, then IDLE.
  - rx_s=0 -> frame_error=1 for one clk, no delivery, then BREAK.
- BREAK: wait for rx_s=1 on a sample edge -> IDLE. A held-low line (break) produces exactly one frame_error and no further frames.
- Undefined state encoding -> IDLE.
- Deliver, evaluated in the clk of the stop-sample edge; outputs update on the next posedge:
  - data_valid=0, or data_ack=1 in the same clk: data<=shift, data_valid<=1, no overrun.
  - data_valid=1 and data_ack=0: new byte dropped, data unchanged, overrun=1 for one clk.
- data_ack with data_valid=1 and no simultaneous delivery: data_valid<=0 next clk.
- data_ack with data_valid=0: ignored.
- data holds its last value after ack.
- Latency: data_valid rises 1 clk after the stop-bit midpoint sample edge, plus SYNC_STAGES clk of synchroniser delay from the pin.
- frame_error and overrun are never asserted in the same clk.
- Sample edges with no pending transition leave all state unchanged.

Test Plan:
1. OVERSAMPLE=16, sample_edge every 4th clk; drive frame 0xA5 at 64 clk/bit -> data=0xA5, data_valid=1 near the stop-bit midpoint, held until data_ack, cleared 1 clk after ack; frame_error=overrun=0.
2. rx low for 4 sample edges then high -> no data_valid, no frame_error. A following frame 0x3C is received as 0x3C.
3. Frame 0x55 with stop bit 0, line then held low 40 bit times -> exactly one frame_error pulse, data_valid stays 0. Release high, send 0x81 -> data=0x81.
4. Frames 0x11 then 0x22 with no ack -> data=0x11, one overrun pulse at the 0x22 stop sample. Ack, then send 0x33 -> data=0x33, no overrun.
5. Assert data_ack in the exact delivery clk of 0x77 while holding 0x66 -> data=0x77, data_valid remains 1, overrun=0.
6. Assert rst=0 mid-DATA of a frame, off a clk edge -> data_valid=0 and data=0 immediately. Release, send 0xF0 -> data=0xF0, no frame_error.
